// File: rtl/rifl_rx_link_mgr.sv
// RIFL rx link manager: HOLD/ALIGN/WAIT_UP/UP/FAULT bring-up FSM, error-rate fault, retransmit pulses; stats counters under RIFL_RX_LINK_STATS_EN.
// Latency: state and retrans_req are registered, so they respond one cycle after the inputs that cause them.
// Backpressure: none; rx_aligned/rx_up are sampled levels and rx_error is a one-cycle pulse.
`timescale 1ns/1ps
module rifl_rx_link_mgr #(
    parameter int RST_HOLD_CYCLES = 64,
    parameter int ALIGN_TIMEOUT   = 65536,
    parameter int ERR_WINDOW      = 4096,
    parameter int ERR_THRESH      = 8,
    parameter int RETRANS_HOLDOFF = 256,
    parameter int STAT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_aligned,
    input  logic                  rx_up,
    input  logic                  rx_error,
    output logic                  frame_rst,
    output logic                  link_up,
    output logic                  retrans_req,
    output logic [2:0]            state,
    output logic [STAT_WIDTH-1:0] err_cnt,
    output logic [STAT_WIDTH-1:0] relock_cnt
);

    localparam int DWELL_MAX = (ALIGN_TIMEOUT > RST_HOLD_CYCLES) ? ALIGN_TIMEOUT : RST_HOLD_CYCLES;
    localparam int DW = $clog2(DWELL_MAX) + 1;
    localparam int WW = $clog2(ERR_WINDOW) + 1;
    localparam int EW = $clog2(ERR_THRESH) + 1;
    localparam int HW = $clog2(RETRANS_HOLDOFF) + 1;

    localparam logic [DW-1:0] HOLD_LAST = DW'(RST_HOLD_CYCLES - 1);
    localparam logic [DW-1:0] TO_LAST   = DW'(ALIGN_TIMEOUT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIMIT = EW'(ERR_THRESH);
    localparam logic [HW-1:0] HOLDOFF_LD = HW'(RETRANS_HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_ALIGN   = 3'd1,
        S_WAIT_UP = 3'd2,
        S_UP      = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t          cur_st;
    state_t          nxt_st;
    logic [DW-1:0]   dwell_cnt;
    logic [WW-1:0]   win_cnt;
    logic [EW-1:0]   win_err;
    logic [EW-1:0]   win_err_nxt;
    logic [HW-1:0]   holdoff_cnt;
    logic            in_up;
    logic            stay_up;
    logic            win_wrap;
    logic            err_trip;

    assign in_up    = (cur_st == S_UP);
    assign stay_up  = in_up && (nxt_st == S_UP);
    assign win_wrap = (win_cnt == WIN_LAST);

    // An error on the wrap cycle opens the new window with a count of one.
    always_comb begin
        win_err_nxt = win_wrap ? EW'(rx_error) : (win_err + EW'(rx_error));
        err_trip    = (win_err_nxt >= ERR_LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st <= S_HOLD;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_HOLD: begin
                if (dwell_cnt == HOLD_LAST) nxt_st = S_ALIGN;
            end
            S_ALIGN: begin
                if (rx_aligned)                nxt_st = S_WAIT_UP;
                else if (dwell_cnt == TO_LAST) nxt_st = S_HOLD;
            end
            S_WAIT_UP: begin
                if (rx_up && rx_aligned)       nxt_st = S_UP;
                else if (!rx_aligned)          nxt_st = S_HOLD;
                else if (dwell_cnt == TO_LAST) nxt_st = S_HOLD;
            end
            S_UP: begin
                if (!rx_up || !rx_aligned || err_trip) nxt_st = S_FAULT;
            end
            S_FAULT: nxt_st = S_HOLD;
            default: nxt_st = S_HOLD;
        endcase
    end

    always_comb begin
        frame_rst = (cur_st == S_HOLD);
        link_up   = (cur_st == S_UP);
        state     = cur_st;
    end

    // One dwell counter serves as the HOLD length and the ALIGN/WAIT_UP timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt <= '0;
        end else if (nxt_st != cur_st) begin
            dwell_cnt <= '0;
        end else if (cur_st == S_HOLD || cur_st == S_ALIGN || cur_st == S_WAIT_UP) begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt     <= '0;
            win_err     <= '0;
            holdoff_cnt <= '0;
            retrans_req <= 1'b0;
        end else begin
            retrans_req <= in_up && rx_error && (holdoff_cnt == '0);
            if (stay_up) begin
                win_cnt <= win_wrap ? '0 : (win_cnt + WW'(1));
                win_err <= win_err_nxt;
                if (rx_error && holdoff_cnt == '0) holdoff_cnt <= HOLDOFF_LD;
                else if (holdoff_cnt != '0)        holdoff_cnt <= holdoff_cnt - HW'(1);
            end else begin
                win_cnt     <= '0;
                win_err     <= '0;
                holdoff_cnt <= '0;
            end
        end
    end

`ifdef RIFL_RX_LINK_STATS_EN
    // A relock event is any entry into HOLD other than through reset.
    logic relock_ev;
    assign relock_ev = (nxt_st == S_HOLD) && (cur_st != S_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt    <= '0;
            relock_cnt <= '0;
        end else begin
            if (in_up && rx_error && err_cnt != '1) err_cnt <= err_cnt + STAT_WIDTH'(1);
            if (relock_ev && relock_cnt != '1)      relock_cnt <= relock_cnt + STAT_WIDTH'(1);
        end
    end
`else
    assign err_cnt    = '0;
    assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_rifl_rx_link_mgr.sv
// Directed bench for rifl_rx_link_mgr with default parameters; stats expectations follow RIFL_RX_LINK_STATS_EN.
`timescale 1ns/1ps
module tb_rifl_rx_link_mgr;

    localparam int SW = 16;
`ifdef RIFL_RX_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_aligned;
    logic          rx_up;
    logic          rx_error;
    logic          frame_rst;
    logic          link_up;
    logic          retrans_req;
    logic [2:0]    state;
    logic [SW-1:0] err_cnt;
    logic [SW-1:0] relock_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    rifl_rx_link_mgr dut (
        .clk         (clk),
        .rst         (rst),
        .rx_aligned  (rx_aligned),
        .rx_up       (rx_up),
        .rx_error    (rx_error),
        .frame_rst   (frame_rst),
        .link_up     (link_up),
        .retrans_req (retrans_req),
        .state       (state),
        .err_cnt     (err_cnt),
        .relock_cnt  (relock_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time expired, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] stat_exp(input int v);
        return STATS ? SW'(v) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_aligned = 1'b0; rx_up = 1'b0; rx_error = 1'b0;
        ticks(3);
        n_checks++; if (state !== 3'd0) $display("FAIL rst_state: got %0d want 0", state); else n_pass++;
        n_checks++; if (frame_rst !== 1'b1) $display("FAIL rst_frame_rst: got %b want 1", frame_rst); else n_pass++;
        n_checks++; if (link_up !== 1'b0) $display("FAIL rst_link_up: got %b want 0", link_up); else n_pass++;
        n_checks++; if (retrans_req !== 1'b0) $display("FAIL rst_retrans: got %b want 0", retrans_req); else n_pass++;
        n_checks++; if (err_cnt !== '0) $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); else n_pass++;
        n_checks++; if (relock_cnt !== '0) $display("FAIL rst_relock_cnt: got %0d want 0", relock_cnt); else n_pass++;
        rst = 1'b0;
        ticks(63);
        n_checks++; if (state !== 3'd0 || frame_rst !== 1'b1) $display("FAIL hold_63: state=%0d frame_rst=%b want 0/1", state, frame_rst); else n_pass++;
        tick();
        n_checks++; if (state !== 3'd1 || frame_rst !== 1'b0) $display("FAIL hold_64_align: state=%0d frame_rst=%b want 1/0", state, frame_rst); else n_pass++;
    endtask

    task automatic test_align_timeout();
        ticks(65535);
        n_checks++; if (state !== 3'd1) $display("FAIL align_before_timeout: state=%0d want 1", state); else n_pass++;
        tick();
        n_checks++; if (state !== 3'd0 || frame_rst !== 1'b1) $display("FAIL align_timeout_hold: state=%0d frame_rst=%b want 0/1", state, frame_rst); else n_pass++;
        n_checks++; if (relock_cnt !== stat_exp(1)) $display("FAIL align_timeout_relock: got %0d want %0d", relock_cnt, stat_exp(1)); else n_pass++;
    endtask

    task automatic test_bringup();
        ticks(64);
        n_checks++; if (state !== 3'd1) $display("FAIL bringup_align: state=%0d want 1", state); else n_pass++;
        rx_aligned = 1'b1;
        tick();
        n_checks++; if (state !== 3'd2) $display("FAIL bringup_wait_up: state=%0d want 2", state); else n_pass++;
        ticks(10);
        n_checks++; if (state !== 3'd2 || link_up !== 1'b0) $display("FAIL bringup_wait_10: state=%0d link_up=%b want 2/0", state, link_up); else n_pass++;
        rx_up = 1'b1;
        tick();
        n_checks++; if (state !== 3'd3) $display("FAIL bringup_up_state: state=%0d want 3", state); else n_pass++;
        n_checks++; if (link_up !== 1'b1 || frame_rst !== 1'b0) $display("FAIL bringup_up_outputs: link_up=%b frame_rst=%b want 1/0", link_up, frame_rst); else n_pass++;
    endtask

    // Cycle numbering: cycle 0 is the first cycle observed in UP.
    task automatic test_retrans();
        int pulses = 0;
        int p1 = -1;
        int p2 = -1;
        for (int c = 0; c <= 310; c++) begin
            rx_error = (c == 0 || c == 5 || c == 300);
            tick();
            if (retrans_req === 1'b1) begin
                pulses++;
                if (pulses == 1) p1 = c + 1;
                if (pulses == 2) p2 = c + 1;
            end
        end
        rx_error = 1'b0;
        n_checks++; if (pulses != 2) $display("FAIL retrans_count: got %0d want 2", pulses); else n_pass++;
        n_checks++; if (p1 != 1) $display("FAIL retrans_first_cycle: got %0d want 1", p1); else n_pass++;
        n_checks++; if (p2 != 301) $display("FAIL retrans_second_cycle: got %0d want 301", p2); else n_pass++;
        n_checks++; if (err_cnt !== stat_exp(3)) $display("FAIL retrans_err_cnt: got %0d want %0d", err_cnt, stat_exp(3)); else n_pass++;
        n_checks++; if (state !== 3'd3) $display("FAIL retrans_still_up: state=%0d want 3", state); else n_pass++;
    endtask

    // Continues from cycle 311; window wraps after cycle 4095.
    task automatic test_err_window();
        int pulses = 0;
        int pcyc = -1;
        for (int c = 311; c <= 4126; c++) begin
            rx_error = (c == 4090 || c == 4092 || c == 4094 || c == 4095 || c == 4097 || c == 4099 ||
                        c == 4101 || c == 4120 || c == 4122 || c == 4124 || c == 4126);
            tick();
            if (retrans_req === 1'b1) begin
                pulses++;
                pcyc = c + 1;
            end
            if (c == 4110) begin
                n_checks++; if (state !== 3'd3) $display("FAIL window_split_stays_up: state=%0d want 3", state); else n_pass++;
            end
            if (c == 4125) begin
                n_checks++; if (state !== 3'd3) $display("FAIL window_seven_stays_up: state=%0d want 3", state); else n_pass++;
            end
        end
        rx_error = 1'b0;
        n_checks++; if (state !== 3'd4 || link_up !== 1'b0) $display("FAIL window_fault: state=%0d link_up=%b want 4/0", state, link_up); else n_pass++;
        n_checks++; if (pulses != 1 || pcyc != 4091) $display("FAIL window_retrans: pulses=%0d at %0d want 1 at 4091", pulses, pcyc); else n_pass++;
        tick();
        n_checks++; if (state !== 3'd0 || frame_rst !== 1'b1) $display("FAIL window_fault_to_hold: state=%0d frame_rst=%b want 0/1", state, frame_rst); else n_pass++;
        n_checks++; if (relock_cnt !== stat_exp(2)) $display("FAIL window_relock: got %0d want %0d", relock_cnt, stat_exp(2)); else n_pass++;
        n_checks++; if (err_cnt !== stat_exp(14)) $display("FAIL window_err_cnt: got %0d want %0d", err_cnt, stat_exp(14)); else n_pass++;
    endtask

    task automatic test_holdoff_clear();
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        n_checks++; if (retrans_req !== 1'b0) $display("FAIL err_in_hold_retrans: got %b want 0", retrans_req); else n_pass++;
        n_checks++; if (err_cnt !== stat_exp(14)) $display("FAIL err_in_hold_err_cnt: got %0d want %0d", err_cnt, stat_exp(14)); else n_pass++;
        ticks(62);
        n_checks++; if (state !== 3'd0) $display("FAIL relock_hold_63: state=%0d want 0", state); else n_pass++;
        ticks(3);
        n_checks++; if (state !== 3'd3 || link_up !== 1'b1) $display("FAIL relock_up: state=%0d link_up=%b want 3/1", state, link_up); else n_pass++;
        rx_error = 1'b1;
        tick();
        rx_error = 1'b0;
        n_checks++; if (retrans_req !== 1'b1) $display("FAIL holdoff_cleared_retrans: got %b want 1", retrans_req); else n_pass++;
    endtask

    task automatic test_link_drop();
        rx_up = 1'b0;
        tick();
        rx_up = 1'b1;
        n_checks++; if (state !== 3'd4 || frame_rst !== 1'b0) $display("FAIL drop_fault: state=%0d frame_rst=%b want 4/0", state, frame_rst); else n_pass++;
        tick();
        n_checks++; if (state !== 3'd0) $display("FAIL drop_hold: state=%0d want 0", state); else n_pass++;
        n_checks++; if (relock_cnt !== stat_exp(3)) $display("FAIL drop_relock: got %0d want %0d", relock_cnt, stat_exp(3)); else n_pass++;
        ticks(30);
        n_checks++; if (state !== 3'd0 || frame_rst !== 1'b1) $display("FAIL drop_mid_hold: state=%0d frame_rst=%b want 0/1", state, frame_rst); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (relock_cnt !== '0 || err_cnt !== '0) $display("FAIL rst_mid_hold_stats: relock=%0d err=%0d want 0/0", relock_cnt, err_cnt); else n_pass++;
        n_checks++; if (state !== 3'd0 || frame_rst !== 1'b1 || link_up !== 1'b0 || retrans_req !== 1'b0)
            $display("FAIL rst_mid_hold_outputs: state=%0d frame_rst=%b link_up=%b retrans=%b want 0/1/0/0", state, frame_rst, link_up, retrans_req);
        else n_pass++;
        ticks(2);
        rst = 1'b0;
        ticks(66);
        n_checks++; if (state !== 3'd3) $display("FAIL rst_rebringup_up: state=%0d want 3", state); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (state !== 3'd0 || link_up !== 1'b0 || frame_rst !== 1'b1)
            $display("FAIL rst_async_in_up: state=%0d link_up=%b frame_rst=%b want 0/0/1", state, link_up, frame_rst);
        else n_pass++;
    endtask

    task automatic test_wait_up_drop();
        tick();
        rst = 1'b0;
        rx_aligned = 1'b1;
        rx_up = 1'b0;
        ticks(65);
        n_checks++; if (state !== 3'd2) $display("FAIL waitup_entry: state=%0d want 2", state); else n_pass++;
        rx_aligned = 1'b0;
        tick();
        n_checks++; if (state !== 3'd0) $display("FAIL waitup_unaligned_hold: state=%0d want 0", state); else n_pass++;
        n_checks++; if (relock_cnt !== stat_exp(1)) $display("FAIL waitup_relock: got %0d want %0d", relock_cnt, stat_exp(1)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_align_timeout();
        test_bringup();
        test_retrans();
        test_err_window();
        test_holdoff_clear();
        test_link_drop();
        test_wait_up_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rifl_rx_link_mgr.md
RIFL_RX_LINK_MGR -- requirements
Module: rifl_rx_link_mgr

Interface
REQ-001 Parameter RST_HOLD_CYCLES, default 64: cycles frame_rst is held in HOLD (>=2).
REQ-002 Parameter ALIGN_TIMEOUT, default 65536: maximum cycles spent in ALIGN or WAIT_UP before relock.
REQ-003 Parameter ERR_WINDOW, default 4096: length in cycles of the error-rate window in UP.
REQ-004 Parameter ERR_THRESH, default 8: rx_error pulses within one window that force FAULT (1..ERR_WINDOW).
REQ-005 Parameter RETRANS_HOLDOFF, default 256: minimum cycles between retrans_req pulses.
REQ-006 Parameter STAT_WIDTH, default 16: width of the statistics counters.
REQ-007 clk  input  1  single block clock; all logic is on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 rx_aligned  input  1  frame alignment lock from the rx aligner (level).
REQ-010 rx_up  input  1  link-up indication from the rx aligner (level).
REQ-011 rx_error  input  1  one-cycle pulse per frame that fails CRC.
REQ-012 frame_rst  output  1  reset for the rx frame-domain datapath.
REQ-013 link_up  output  1  high only in state UP.
REQ-014 retrans_req  output  1  one-cycle retransmission request pulse.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 err_cnt  output  STAT_WIDTH  saturating count of rx_error pulses seen in UP.
REQ-017 relock_cnt  output  STAT_WIDTH  saturating count of relock events.

Function
REQ-018 FSM states and encodings SHALL be HOLD=0, ALIGN=1, WAIT_UP=2, UP=3, FAULT=4; state is registered and drives the state output directly.
REQ-019 frame_rst SHALL be 1 exactly while state==HOLD; link_up SHALL be 1 exactly while state==UP (Moore outputs, no combinational path from inputs).
REQ-020 HOLD: a hold counter clears on entry; HOLD lasts exactly RST_HOLD_CYCLES cycles, then goes to ALIGN.
REQ-021 ALIGN: rx_aligned=1 -> WAIT_UP next cycle; otherwise after ALIGN_TIMEOUT cycles in state -> HOLD with relock_cnt+1.
REQ-022 WAIT_UP: rx_up=1 and rx_aligned=1 -> UP; rx_aligned=0 -> HOLD with relock_cnt+1; ALIGN_TIMEOUT cycles in state -> HOLD with relock_cnt+1; the timeout counter clears on every state entry.
REQ-023 UP: rx_up=0 or rx_aligned=0 -> FAULT; window error count reaching ERR_THRESH -> FAULT; both conditions in one cycle give one FAULT entry.
REQ-024 Error window: counter runs 0..ERR_WINDOW-1 in UP and wraps; window error count clears at wrap; an rx_error on the wrap cycle counts as 1 in the new window.
REQ-025 FAULT SHALL last exactly one cycle, increment relock_cnt, then go to HOLD.
REQ-026 retrans_req: in UP, an rx_error with holdoff counter==0 produces a pulse the next cycle and loads holdoff with RETRANS_HOLDOFF-1.
REQ-027 rx_error during holdoff, or outside UP, SHALL not pulse retrans_req; the holdoff counter clears on leaving UP.
REQ-028 err_cnt increments on each rx_error in UP; err_cnt and relock_cnt saturate at all-ones and never wrap.
REQ-029 Window, holdoff and timeout counters are sized $clog2 of their parameter plus 1 and never overflow.

Reset
REQ-030 While rst=1, all outputs SHALL take these values asynchronously: state=HOLD, frame_rst=1, link_up=0, retrans_req=0, err_cnt=0, relock_cnt=0; all internal counters are 0.
REQ-031 The HOLD count starts on the first clk edge after rst deasserts; asserting rst in any state returns to HOLD immediately.

Configuration
REQ-032 Macro RIFL_RX_LINK_STATS_EN defined: err_cnt and relock_cnt are implemented per REQ-016/017/028.
REQ-033 Macro RIFL_RX_LINK_STATS_EN undefined: err_cnt and relock_cnt are tied to 0 and no counter logic exists; FSM, frame_rst, link_up and retrans_req are cycle-identical to the defined build.

Verification
REQ-034 Release rst with rx_aligned=0 -> frame_rst=1 for 64 cycles, state=ALIGN at cycle 64, relock_cnt=1 after 65536 more cycles, then HOLD again.
REQ-035 rx_aligned=1 in ALIGN, then rx_up=1 after 10 cycles -> state WAIT_UP, then UP; link_up=1 and frame_rst=0.
REQ-036 In UP, rx_error pulses at cycles 0 and 5 -> exactly one retrans_req, at cycle 1; a third rx_error at cycle 300 -> retrans_req at cycle 301; err_cnt=3.
REQ-037 In UP, 8 rx_error pulses within one 4096-cycle window -> FAULT for 1 cycle, then HOLD; relock_cnt+1; 7 pulses split across a wrap -> stays UP.
REQ-038 In UP, drop rx_up for 1 cycle -> FAULT, then HOLD for 64 cycles; rst asserted mid-HOLD -> all outputs at reset values immediately.
REQ-039 Build without RIFL_RX_LINK_STATS_EN, rerun REQ-037 -> identical state/frame_rst/retrans_req trace; err_cnt=relock_cnt=0.
